// File: rtl/cpu_run_monitor.sv
// Run controller for the single-cycle processor.
// It sequences the processor's active-low reset and watches the PC every RUN cycle.
// A run ends when the PC sits on a self-branch (halt) or when the cycle budget is used up
// (timeout). At that point the cycle count, final PC and result are frozen for the bench.
module cpu_run_monitor #(
  parameter int          PC_W         = 6,
  parameter int          CNT_W        = 32,
  parameter int          RST_CYCLES   = 2,
  parameter int          HALT_STABLE  = 4,
  parameter int          MAX_CYCLES   = 1000,
  parameter logic [31:0] EXPECTED_RES = 32'd0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [31:0]      res_i,
  output logic             cpu_rst_n_o,
  output logic             running_o,
  output logic             done_o,
  output logic             halted_o,
  output logic             timeout_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [PC_W-1:0]  final_pc_o,
  output logic [31:0]      final_res_o
);

  localparam int RCNT_W   = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES + 1)  : 1;
  localparam int STABLE_W = (HALT_STABLE > 1) ? $clog2(HALT_STABLE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } state_t;

  state_t              state_q;
  logic [RCNT_W-1:0]   resetCnt_q;
  logic [STABLE_W-1:0] stableCnt_q;
  logic [PC_W-1:0]     prevPc_q;
  logic                firstRun_q;
  logic                cpuRstN_q;
  logic                running_q;
  logic                done_q;
  logic                halted_q;
  logic                timeout_q;
  logic                pass_q;
  logic [CNT_W-1:0]    cycles_q;
  logic [PC_W-1:0]     finalPc_q;
  logic [31:0]         finalRes_q;

  logic [CNT_W-1:0]    cycles_d;
  logic                pcSame;
  logic                haltHit;
  logic                timeoutHit;
  logic                resMatch;

  // Halt/timeout detection for the current RUN sample. The first RUN sample has no
  // previous PC to compare against, so it can never count as a halt.
  always_comb begin
    cycles_d   = cycles_q + 1'b1;
    pcSame     = (pc_i == prevPc_q);
    haltHit    = !firstRun_q && pcSame &&
                 (stableCnt_q == STABLE_W'(HALT_STABLE - 2));
    timeoutHit = (cycles_d == CNT_W'(MAX_CYCLES));
    resMatch   = (res_i == EXPECTED_RES);
  end

  // Run sequencer: all state and outputs are registered here; abort beats start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      resetCnt_q  <= '0;
      stableCnt_q <= '0;
      prevPc_q    <= '0;
      firstRun_q  <= 1'b0;
      cpuRstN_q   <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      cycles_q    <= '0;
      finalPc_q   <= '0;
      finalRes_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q    <= RESET;
            resetCnt_q <= '0;
            cpuRstN_q  <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            cycles_q   <= '0;
            finalPc_q  <= '0;
            finalRes_q <= '0;
          end
        end

        RESET, RUN: begin
          if (abort_i) begin
            state_q   <= IDLE;
            cpuRstN_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
          end else if (state_q == RESET) begin
            if (resetCnt_q == RCNT_W'(RST_CYCLES - 1)) begin
              state_q    <= RUN;
              cpuRstN_q  <= 1'b1;
              running_q  <= 1'b1;
              firstRun_q <= 1'b1;
            end else begin
              resetCnt_q <= resetCnt_q + 1'b1;
            end
          end else begin
            cycles_q   <= cycles_d;
            prevPc_q   <= pc_i;
            firstRun_q <= 1'b0;
            if (firstRun_q || !pcSame) begin
              stableCnt_q <= '0;
            end else begin
              stableCnt_q <= stableCnt_q + 1'b1;
            end
            if (haltHit || timeoutHit) begin
              state_q    <= DONE;
              halted_q   <= haltHit;
              timeout_q  <= !haltHit;
              pass_q     <= haltHit && resMatch;
              finalPc_q  <= pc_i;
              finalRes_q <= res_i;
              done_q     <= 1'b1;
              running_q  <= 1'b0;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rst_n_o = cpuRstN_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign halted_o    = halted_q;
  assign timeout_o   = timeout_q;
  assign pass_o      = pass_q;
  assign cycles_o    = cycles_q;
  assign final_pc_o  = finalPc_q;
  assign final_res_o = finalRes_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor. Two instances share one stimulus stream:
// dutA has a 20-cycle budget and expects result 5, dutB has a 7-cycle budget and
// expects result 0 (used for the simultaneous halt/timeout case).
module tb_cpu_run_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [5:0]  pc;
  logic [31:0] res;

  logic        aCpuRstN, aRunning, aDone, aHalted, aTimeout, aPass;
  logic [31:0] aCycles;
  logic [5:0]  aFinalPc;
  logic [31:0] aFinalRes;

  logic        bCpuRstN, bRunning, bDone, bHalted, bTimeout, bPass;
  logic [31:0] bCycles;
  logic [5:0]  bFinalPc;
  logic [31:0] bFinalRes;

  int testsRun;
  int testsFailed;

  cpu_run_monitor #(
    .PC_W(6), .CNT_W(32), .RST_CYCLES(2), .HALT_STABLE(4),
    .MAX_CYCLES(20), .EXPECTED_RES(32'd5)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .pc_i(pc), .res_i(res),
    .cpu_rst_n_o(aCpuRstN), .running_o(aRunning), .done_o(aDone),
    .halted_o(aHalted), .timeout_o(aTimeout), .pass_o(aPass),
    .cycles_o(aCycles), .final_pc_o(aFinalPc), .final_res_o(aFinalRes)
  );

  cpu_run_monitor #(
    .PC_W(6), .CNT_W(32), .RST_CYCLES(2), .HALT_STABLE(4),
    .MAX_CYCLES(7), .EXPECTED_RES(32'd0)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .pc_i(pc), .res_i(res),
    .cpu_rst_n_o(bCpuRstN), .running_o(bRunning), .done_o(bDone),
    .halted_o(bHalted), .timeout_o(bTimeout), .pass_o(bPass),
    .cycles_o(bCycles), .final_pc_o(bFinalPc), .final_res_o(bFinalRes)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock's worth of inputs, then step to just after the rising edge.
  task automatic applyStimulus(input logic s, input logic a, input logic [5:0] p);
    start = s;
    abort = a;
    pc    = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Start a run and step through the two reset clocks into RUN.
  task automatic startRun();
    applyStimulus(1'b1, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 6'd0);
  endtask

  // Directed scenario sequence.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pc    = 6'd0;
    res   = 32'd0;

    // Reset state, with start held high to show rst overrides it.
    applyStimulus(1'b1, 1'b0, 6'd0);
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("rst cpu_rst_n", {31'd0, aCpuRstN}, 32'd0);
    checkOutput("rst running",   {31'd0, aRunning}, 32'd0);
    checkOutput("rst done",      {31'd0, aDone},    32'd0);
    checkOutput("rst cycles",    aCycles,           32'd0);
    rst = 1'b0;

    // Scenario 1: reset sequencing, then halt on the 4th identical PC of 9.
    res = 32'd3;
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("s1 reset clk1 cpu_rst_n", {31'd0, aCpuRstN}, 32'd0);
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("s1 reset clk2 cpu_rst_n", {31'd0, aCpuRstN}, 32'd0);
    checkOutput("s1 reset clk2 running",   {31'd0, aRunning}, 32'd0);
    applyStimulus(1'b0, 1'b0, 6'd0);
    checkOutput("s1 run cpu_rst_n", {31'd0, aCpuRstN}, 32'd1);
    checkOutput("s1 run running",   {31'd0, aRunning}, 32'd1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 6'(i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 6'd9);
    checkOutput("s1 pre-halt done",   {31'd0, aDone}, 32'd0);
    checkOutput("s1 pre-halt cycles", aCycles,        32'd12);
    applyStimulus(1'b0, 1'b0, 6'd9);
    checkOutput("s1 done",      {31'd0, aDone},    32'd1);
    checkOutput("s1 halted",    {31'd0, aHalted},  32'd1);
    checkOutput("s1 timeout",   {31'd0, aTimeout}, 32'd0);
    checkOutput("s1 running",   {31'd0, aRunning}, 32'd0);
    checkOutput("s1 cycles",    aCycles,           32'd13);
    checkOutput("s1 final_pc",  {26'd0, aFinalPc}, 32'd9);
    checkOutput("s1 final_res", aFinalRes,         32'd3);
    checkOutput("s1 pass",      {31'd0, aPass},    32'd0);

    // Outputs hold in DONE; abort there is ignored.
    res = 32'd44;
    applyStimulus(1'b0, 1'b0, 6'd30);
    applyStimulus(1'b0, 1'b1, 6'd31);
    checkOutput("hold done",      {31'd0, aDone},    32'd1);
    checkOutput("hold cpu_rst_n", {31'd0, aCpuRstN}, 32'd1);
    checkOutput("hold cycles",    aCycles,           32'd13);
    checkOutput("hold final_pc",  {26'd0, aFinalPc}, 32'd9);
    checkOutput("hold final_res", aFinalRes,         32'd3);

    // Scenario 3: restart from DONE with the expected result, then with a wrong one.
    res = 32'd5;
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("s3 restart cycles", aCycles,          32'd0);
    checkOutput("s3 restart done",   {31'd0, aDone},   32'd0);
    checkOutput("s3 restart halted", {31'd0, aHalted}, 32'd0);
    applyStimulus(1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 6'd1);
    applyStimulus(1'b0, 1'b0, 6'd2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 6'd3);
    checkOutput("s3a halted",    {31'd0, aHalted}, 32'd1);
    checkOutput("s3a pass",      {31'd0, aPass},   32'd1);
    checkOutput("s3a cycles",    aCycles,          32'd6);
    checkOutput("s3a final_res", aFinalRes,        32'd5);
    res = 32'd7;
    startRun();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 6'd4);
    checkOutput("s3b halted",    {31'd0, aHalted}, 32'd1);
    checkOutput("s3b pass",      {31'd0, aPass},   32'd0);
    checkOutput("s3b cycles",    aCycles,          32'd4);
    checkOutput("s3b final_res", aFinalRes,        32'd7);

    // Scenario 2: PC changes every clock (wrapping 63 -> 0) until the 20-cycle budget runs out.
    res = 32'd5;
    startRun();
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 6'((60 + i) % 64));
    checkOutput("s2 pre-timeout done", {31'd0, aDone}, 32'd0);
    applyStimulus(1'b0, 1'b0, 6'((60 + 19) % 64));
    checkOutput("s2 done",     {31'd0, aDone},    32'd1);
    checkOutput("s2 timeout",  {31'd0, aTimeout}, 32'd1);
    checkOutput("s2 halted",   {31'd0, aHalted},  32'd0);
    checkOutput("s2 pass",     {31'd0, aPass},    32'd0);
    checkOutput("s2 cycles",   aCycles,           32'd20);
    checkOutput("s2 final_pc", {26'd0, aFinalPc}, 32'd15);

    // Scenario 5: abort after five RUN samples, then abort+start together.
    startRun();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 6'(10 + i));
    applyStimulus(1'b0, 1'b1, 6'd15);
    checkOutput("s5 abort cpu_rst_n", {31'd0, aCpuRstN}, 32'd0);
    checkOutput("s5 abort running",   {31'd0, aRunning}, 32'd0);
    checkOutput("s5 abort done",      {31'd0, aDone},    32'd0);
    checkOutput("s5 abort cycles",    aCycles,           32'd5);
    applyStimulus(1'b0, 1'b0, 6'd15);
    applyStimulus(1'b0, 1'b0, 6'd15);
    checkOutput("s5 idle cpu_rst_n", {31'd0, aCpuRstN}, 32'd0);
    startRun();
    applyStimulus(1'b0, 1'b0, 6'd20);
    applyStimulus(1'b0, 1'b0, 6'd21);
    applyStimulus(1'b1, 1'b1, 6'd22);
    checkOutput("s5 abort+start running", {31'd0, aRunning}, 32'd0);
    checkOutput("s5 abort+start cycles",  aCycles,           32'd2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 6'd22);
    checkOutput("s5 abort+start idle cpu_rst_n", {31'd0, aCpuRstN}, 32'd0);
    checkOutput("s5 abort+start idle cycles",    aCycles,           32'd2);

    // Scenario 4 on dutB: halt and timeout land on the same (7th) cycle; halt wins.
    res = 32'd0;
    startRun();
    applyStimulus(1'b0, 1'b0, 6'd1);
    applyStimulus(1'b0, 1'b0, 6'd2);
    applyStimulus(1'b0, 1'b0, 6'd3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 6'd7);
    checkOutput("s4 pre-end done", {31'd0, bDone}, 32'd0);
    applyStimulus(1'b0, 1'b0, 6'd7);
    checkOutput("s4 done",     {31'd0, bDone},    32'd1);
    checkOutput("s4 halted",   {31'd0, bHalted},  32'd1);
    checkOutput("s4 timeout",  {31'd0, bTimeout}, 32'd0);
    checkOutput("s4 pass",     {31'd0, bPass},    32'd1);
    checkOutput("s4 cycles",   bCycles,           32'd7);
    checkOutput("s4 final_pc", {26'd0, bFinalPc}, 32'd7);

    // Scenario 6: rst in the middle of a run on dutA clears everything.
    startRun();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 6'(40 + i));
    checkOutput("s6 pre-rst cycles", aCycles, 32'd3);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd43);
    checkOutput("s6 cpu_rst_n", {31'd0, aCpuRstN}, 32'd0);
    checkOutput("s6 running",   {31'd0, aRunning}, 32'd0);
    checkOutput("s6 done",      {31'd0, aDone},    32'd0);
    checkOutput("s6 cycles",    aCycles,           32'd0);
    checkOutput("s6 B final_pc", {26'd0, bFinalPc}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd43);
    applyStimulus(1'b0, 1'b0, 6'd43);
    applyStimulus(1'b0, 1'b0, 6'd43);
    checkOutput("s6 stays idle cpu_rst_n", {31'd0, aCpuRstN}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
